// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl_pkg
// Purpose  : Shared constants for the EX-stage multiply/divide sequencer:
//            EX-stage op encodings, sequencer state encodings, default divide
//            iteration count and a small conditional-negate helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // EX-stage op codes for the HI/LO arithmetic group
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Sequencer state encodings
    localparam logic [1:0] MD_IDLE    = 2'd0;
    localparam logic [1:0] MD_MUL_RUN = 2'd1;
    localparam logic [1:0] MD_DIV_RUN = 2'd2;
    localparam logic [1:0] MD_DONE    = 2'd3;

    // One quotient bit per iteration for a 32-bit dividend
    localparam int DIV_ITER_DFLT = 32;

    typedef enum logic [1:0] {
        S_IDLE    = MD_IDLE,
        S_MUL_RUN = MD_MUL_RUN,
        S_DIV_RUN = MD_DIV_RUN,
        S_DONE    = MD_DONE
    } md_state_e;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_div_radix2_core.sv
`default_nettype none
// ============================================================================
// Module   : div_radix2_core
// Purpose  : Unsigned radix-2 restoring divide datapath. i_start loads the
//            magnitudes; each i_step shifts one dividend bit into the partial
//            remainder and performs one trial subtract. The post-step values
//            are exposed combinationally so the owner can capture the final
//            result on the same edge as the last step.
// Ports    : clk, rst       - clock / asynchronous active-high reset
//            i_start        - load operands, clear step count
//            i_dividend     - dividend magnitude
//            i_divisor      - divisor magnitude (non-zero)
//            i_step         - perform one iteration this cycle
//            o_rem_next     - remainder after the current step
//            o_quot_next    - quotient after the current step
//            o_last         - current step is the final iteration
// Revision : 1.0 - initial release
// ============================================================================
module div_radix2_core #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_step,
    output logic [31:0] o_rem_next,
    output logic [31:0] o_quot_next,
    output logic        o_last
);

    localparam int c_STEP_W = $clog2(DIV_ITER + 1);

    logic [31:0]         r_rem;
    logic [31:0]         r_quot;
    logic [31:0]         r_divisor;
    logic [c_STEP_W-1:0] r_steps;

    logic [32:0] w_partial;
    logic [33:0] w_sub;
    logic        w_fits;
    logic        w_unused_msb;

    // Partial remainder can reach 33 bits (2*rem+1 with rem < divisor),
    // so the trial subtract needs a borrow bit above that.
    assign w_partial    = {r_rem, r_quot[31]};
    assign w_sub        = {1'b0, w_partial} - {2'b00, r_divisor};
    assign w_fits       = ~w_sub[33];
    // When the subtract fits the difference is below the divisor, so bit 32 is zero
    assign w_unused_msb = w_sub[32];

    assign o_rem_next  = w_fits ? w_sub[31:0] : w_partial[31:0];
    assign o_quot_next = {r_quot[30:0], w_fits};
    assign o_last      = (r_steps == c_STEP_W'(DIV_ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_steps   <= '0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_steps   <= '0;
        end else if (i_step) begin
            r_rem     <= o_rem_next;
            r_quot    <= o_quot_next;
            r_steps   <= r_steps + c_STEP_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : EX-stage sequencer for MULT/MULTU/DIV/DIVU. Launches a
//            multi-cycle multiply or restoring divide, stalls the pipeline
//            until the result is ready, then pulses a single HI/LO write.
//            Honours exception flush and external stalls.
// Ports    : clk, rst      - clock / asynchronous active-high reset
//            alucontrolE   - EX-stage op code
//            srcaE, srcbE  - rs / rt operands
//            flushE        - cancel in-flight op
//            stall_ext     - pipeline frozen by another source this cycle
//            stall_mdE     - stall request while an op is in progress
//            hilo_we       - one-shot HI/LO write strobe
//            hi_o, lo_o    - HI (remainder / product high), LO (quotient / product low)
//            busy          - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITER   = DIV_ITER_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flushE,
    input  logic        stall_ext,
    output logic        stall_mdE,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    localparam int c_CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    md_state_e           r_state;
    md_state_e           w_state_next;
    logic [c_CNT_W-1:0]  r_count;
    logic signed [32:0]  r_mul_a;
    logic signed [32:0]  r_mul_b;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic                w_is_mul;
    logic                w_is_div;
    logic                w_is_signed;
    logic                w_stall;
    logic                w_we;
    logic                w_launch_mul;
    logic                w_launch_div;
    logic                w_launch_dz;
    logic                w_div_step;
    logic                w_div_last;
    logic                w_run_active;
    logic [31:0]         w_mag_a;
    logic [31:0]         w_mag_b;
    logic [31:0]         w_rem_next;
    logic [31:0]         w_quot_next;
    logic signed [63:0]  w_prod;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_is_mul    = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
    assign w_is_div    = (alucontrolE == EXE_DIV_OP)  || (alucontrolE == EXE_DIVU_OP);
    assign w_is_signed = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_DIV_OP);

    // The divider core works on magnitudes; signs are re-applied at capture
    assign w_mag_a = cond_neg(srcaE, w_is_signed & srcaE[31]);
    assign w_mag_b = cond_neg(srcbE, w_is_signed & srcbE[31]);

    // ------------------------------------------------------------------
    // Next-state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_we         = 1'b0;
        w_launch_mul = 1'b0;
        w_launch_div = 1'b0;
        w_launch_dz  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flushE && (w_is_mul || w_is_div)) begin
                    w_stall = 1'b1;
                    if (w_is_mul) begin
                        w_launch_mul = 1'b1;
                        w_state_next = S_MUL_RUN;
                    end else if (srcbE == 32'd0) begin
                        // Divide by zero yields a fixed result without iterating
                        w_launch_dz  = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_launch_div = 1'b1;
                        w_state_next = S_DIV_RUN;
                    end
                end
            end
            S_MUL_RUN, S_DIV_RUN: begin
                if (flushE) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_count == '0) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Flush wins over the write; stall_ext holds the result here
                if (flushE) begin
                    w_state_next = S_IDLE;
                end else if (!stall_ext) begin
                    w_we         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_run_active = ((r_state == S_MUL_RUN) || (r_state == S_DIV_RUN)) && !flushE;
    assign w_div_step   = (r_state == S_DIV_RUN) && !flushE;

    // Operands were extended to 33 bits at issue (sign or zero), so a signed
    // 64-bit product covers MULT and MULTU alike.
    assign w_prod = 64'(r_mul_a) * 64'(r_mul_b);

    div_radix2_core #(
        .DIV_ITER    (DIV_ITER)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_launch_div),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .i_step      (w_div_step),
        .o_rem_next  (w_rem_next),
        .o_quot_next (w_quot_next),
        .o_last      (w_div_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_launch_mul) begin
                r_mul_a <= {w_is_signed & srcaE[31], srcaE};
                r_mul_b <= {w_is_signed & srcbE[31], srcbE};
                r_count <= c_CNT_W'(MUL_CYCLES - 1);
            end
            if (w_launch_div) begin
                r_neg_q <= w_is_signed & (srcaE[31] ^ srcbE[31]);
                r_neg_r <= w_is_signed & srcaE[31];
                r_count <= c_CNT_W'(DIV_ITER - 1);
            end
            if (w_launch_dz) begin
                r_hi <= srcaE;
                r_lo <= 32'hFFFF_FFFF;
            end
            if (w_run_active && (r_count != '0)) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if ((r_state == S_MUL_RUN) && !flushE && (r_count == '0)) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
            // Capture on the final iteration using the post-step values
            if (w_div_step && w_div_last) begin
                r_hi <= cond_neg(w_rem_next, r_neg_r);
                r_lo <= cond_neg(w_quot_next, r_neg_q);
            end
        end
    end

    assign stall_mdE = w_stall;
    assign hilo_we   = w_we;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Self-checking bench for muldiv_ctrl. Expected HI/LO pairs are
//            queued at issue and popped whenever hilo_we is observed.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int         MUL_CYCLES = 2;
    localparam int         DIV_ITER   = 32;
    localparam logic [7:0] c_NOP      = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stall_ext;
    logic        stall_mdE;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MUL_CYCLES  (MUL_CYCLES),
        .DIV_ITER    (DIV_ITER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alucontrolE (alucontrolE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .flushE      (flushE),
        .stall_ext   (stall_ext),
        .stall_mdE   (stall_mdE),
        .hilo_we     (hilo_we),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .busy        (busy)
    );

    // Scoreboard: every write strobe must match the oldest queued result
    always @(negedge clk) begin
        if (hilo_we === 1'b1) begin
            logic [63:0] w_exp;
            n_we++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL hilo_we_unexpected: got hi=%h lo=%h, required no write", hi_o, lo_o);
            end else begin
                w_exp = sb_q.pop_front();
                if ({hi_o, lo_o} !== w_exp) begin
                    n_fail++;
                    $display("FAIL hilo_result: got hi=%h lo=%h, required hi=%h lo=%h",
                             hi_o, lo_o, w_exp[63:32], w_exp[31:0]);
                end
            end
        end
    end

    function automatic logic [63:0] model_div(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == EXE_DIV_OP) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [63:0] model_mul(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (op == EXE_MULT_OP) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Issue one op, hold it while stalled (scrambling operands after issue),
    // then check stall length and that exactly one write occurred.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall, input string name);
        int st;
        int we0;
        if ((op == EXE_MULT_OP) || (op == EXE_MULTU_OP)) sb_q.push_back(model_mul(op, a, b));
        else                                             sb_q.push_back(model_div(op, a, b));
        we0 = n_we;
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        st          = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall_mdE === 1'b1) begin
                st++;
                if (st == 2) begin
                    srcaE = $urandom;
                    srcbE = $urandom;
                end
            end else begin
                break;
            end
        end
        @(posedge clk);
        #1;
        alucontrolE = c_NOP;
        n_tests++;
        if (st != exp_stall) begin
            n_fail++;
            $display("FAIL %s_stall_cycles: got %0d, required %0d", name, st, exp_stall);
        end
        n_tests++;
        if (n_we != we0 + 1) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, required 1", name, n_we - we0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({stall_mdE, hilo_we, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got stall=%b we=%b busy=%b, required 0 0 0",
                     stall_mdE, hilo_we, busy);
        end
        n_tests++;
        if ({hi_o, lo_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got hi=%h lo=%h, required 0 0", hi_o, lo_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b, required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divide();
        logic [7:0]  op;
        logic [31:0] a, b;
        run_op(EXE_DIVU_OP, 32'd100, 32'd7, 1 + DIV_ITER, "divu_100_7");
        run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1 + DIV_ITER, "div_m7_2");
        run_op(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 1 + DIV_ITER, "div_7_m2");
        for (int i = 0; i < 6; i++) begin
            op = (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd1;
            if ((op == EXE_DIV_OP) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) b = 32'd3;
            run_op(op, a, b, 1 + DIV_ITER, "div_rand");
        end
    endtask

    task automatic test_multiply();
        run_op(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 1 + MUL_CYCLES, "mult_m2_3");
        run_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1 + MUL_CYCLES, "multu_max");
        for (int i = 0; i < 4; i++) begin
            run_op((i % 2 == 0) ? EXE_MULT_OP : EXE_MULTU_OP, $urandom, $urandom,
                   1 + MUL_CYCLES, "mul_rand");
        end
    endtask

    task automatic test_div_zero();
        run_op(EXE_DIVU_OP, 32'd5, 32'd0, 1, "divu_5_0");
        run_op(EXE_DIV_OP, 32'hFFFF_FF00, 32'd0, 1, "div_neg_0");
    endtask

    task automatic test_back_to_back();
        run_op(EXE_MULTU_OP, 32'd12345, 32'd678, 1 + MUL_CYCLES, "b2b_mul");
        run_op(EXE_DIVU_OP, 32'd1000, 32'd9, 1 + DIV_ITER, "b2b_div");
        run_op(EXE_MULT_OP, 32'h8000_0000, 32'd2, 1 + MUL_CYCLES, "b2b_mult");
    endtask

    task automatic test_flush();
        int we0;
        we0 = n_we;
        alucontrolE = EXE_DIVU_OP;
        srcaE       = 32'd1000;
        srcbE       = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if ({stall_mdE, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_pre_run: got stall=%b busy=%b, required 1 1", stall_mdE, busy);
        end
        flushE      = 1'b1;
        alucontrolE = c_NOP;
        #1;
        n_tests++;
        if (stall_mdE !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall_same_cycle: got %b, required 0", stall_mdE);
        end
        @(posedge clk);
        #1;
        flushE = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_next: got %b, required 0", busy);
        end
        repeat (40) @(posedge clk);
        #1;
        n_tests++;
        if (n_we != we0) begin
            n_fail++;
            $display("FAIL flush_no_write: got %0d writes, required 0", n_we - we0);
        end
        // Flush in IDLE suppresses the launch
        alucontrolE = EXE_DIV_OP;
        srcaE       = 32'd50;
        srcbE       = 32'd5;
        flushE      = 1'b1;
        #1;
        n_tests++;
        if (stall_mdE !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_stall: got %b, required 0", stall_mdE);
        end
        @(posedge clk);
        #1;
        flushE      = 1'b0;
        alucontrolE = c_NOP;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_launch: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_stall_ext();
        int we0;
        int st;
        sb_q.push_back(model_div(EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7));
        we0         = n_we;
        stall_ext   = 1'b1;
        alucontrolE = EXE_DIV_OP;
        srcaE       = 32'hFFFF_FF9C;
        srcbE       = 32'd7;
        st          = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall_mdE === 1'b1) st++;
            else break;
        end
        n_tests++;
        if (st != 1 + DIV_ITER) begin
            n_fail++;
            $display("FAIL stallext_run_len: got %0d, required %0d", st, 1 + DIV_ITER);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if ({hilo_we, busy, stall_mdE} !== 3'b010) begin
                n_fail++;
                $display("FAIL stallext_hold: got we=%b busy=%b stall=%b, required 0 1 0",
                         hilo_we, busy, stall_mdE);
            end
        end
        @(posedge clk);
        #1;
        stall_ext = 1'b0;
        @(negedge clk);
        n_tests++;
        if (hilo_we !== 1'b1) begin
            n_fail++;
            $display("FAIL stallext_release: got we=%b, required 1", hilo_we);
        end
        @(posedge clk);
        #1;
        alucontrolE = c_NOP;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stallext_no_relaunch: got busy=%b, required 0", busy);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (n_we != we0 + 1) begin
            n_fail++;
            $display("FAIL stallext_write_count: got %0d, required 1", n_we - we0);
        end
    endtask

    task automatic test_rst_mid();
        alucontrolE = EXE_DIVU_OP;
        srcaE       = 32'd999;
        srcbE       = 32'd4;
        repeat (5) @(posedge clk);
        #2;
        rst         = 1'b1;
        alucontrolE = c_NOP;
        #1;
        n_tests++;
        if ({stall_mdE, hilo_we, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got stall=%b we=%b busy=%b, required 0 0 0",
                     stall_mdE, hilo_we, busy);
        end
        n_tests++;
        if ({hi_o, lo_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL rstmid_hilo: got hi=%h lo=%h, required 0 0", hi_o, lo_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got busy=%b, required 0", busy);
        end
    endtask

    initial begin
        rst         = 1'b1;
        alucontrolE = c_NOP;
        srcaE       = '0;
        srcbE       = '0;
        flushE      = 1'b0;
        stall_ext   = 1'b0;
        test_reset();
        test_divide();
        test_multiply();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_stall_ext();
        test_rst_mid();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
